// File: rtl/mario_sprite_pkg.sv
// Shared constants and types for the 21x21 Mario sprite fetch path.
// Also holds the row/column to ROM-address helper.
package mario_sprite_pkg;

    localparam int          SPR_W     = 21;
    localparam int          SPR_H     = 21;
    localparam logic [23:0] KEY_COLOR = 24'h800080;

    typedef enum logic [0:0] {
        ANIM_IDLE = 1'b0,
        ANIM_WALK = 1'b1
    } anim_state_t;

    // Row-major ROM address; at most 20*21+20 = 440, so it always fits in 9 bits.
    function automatic logic [8:0] sprite_addr(input logic [4:0] row, input logic [4:0] col);
        logic [9:0] prod;
        prod = ({5'd0, row} * 10'd21) + {5'd0, col};
        return prod[8:0];
    endfunction

endpackage

// File: rtl/vsync_edge_sync.sv
// Brings the asynchronous vsync into the clock domain through two flops.
// It then emits a one-clock pulse on each rising edge.
module vsync_edge_sync (
    input  logic clk,
    input  logic rst_n,
    input  logic async_in,
    output logic tick
);

    logic meta_r;
    logic sync_r;
    logic prev_r;

    // Synchroniser chain plus registered rising-edge pulse
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta_r <= 1'b0;
            sync_r <= 1'b0;
            prev_r <= 1'b0;
            tick   <= 1'b0;
        end else begin
            meta_r <= async_in;
            sync_r <= meta_r;
            prev_r <= sync_r;
            tick   <= sync_r & ~prev_r;
        end
    end

endmodule

// File: rtl/mario_sprite_fetch.sv
// Maps the scan position onto the Mario sprite ROM and selects the walk frame.
// Keys out the transparent colour and presents a registered pixel two clocks later.
module mario_sprite_fetch
    import mario_sprite_pkg::*;
#(
    parameter int STEP_VSYNCS = 6
) (
    input  logic        Clk,
    input  logic        Reset_n,
    input  logic        frame_clk,
    input  logic [9:0]  DrawX,
    input  logic [9:0]  DrawY,
    input  logic [9:0]  MarioX,
    input  logic [9:0]  MarioY,
    input  logic        walking,
    input  logic        face_left,
    output logic [8:0]  read_address,
    output logic [1:0]  frame_sel,
    input  logic [23:0] rom_color,
    output logic        sprite_on,
    output logic [23:0] sprite_color
);

    localparam int STEP_W = (STEP_VSYNCS > 1) ? $clog2(STEP_VSYNCS) : 1;
    localparam logic [STEP_W-1:0] STEP_LAST = STEP_W'(STEP_VSYNCS - 1);

    logic               vs_tick_s;
    anim_state_t        state_r;
    anim_state_t        state_nxt_s;
    logic [STEP_W-1:0]  step_r;
    logic [STEP_W-1:0]  step_nxt_s;
    logic [1:0]         frame_nxt_s;

    logic signed [10:0] dx_s;
    logic signed [10:0] dy_s;
    logic               in_box_s;
    logic [4:0]         col_s;
    logic [8:0]         addr_s;
    logic               in_box_d1_r;
    logic               opaque_s;

    vsync_edge_sync u_vsync (
        .clk      (Clk),
        .rst_n    (Reset_n),
        .async_in (frame_clk),
        .tick     (vs_tick_s)
    );

    // Animation next-state: only a vsync tick may move the state or frame
    always_comb begin
        state_nxt_s = state_r;
        step_nxt_s  = step_r;
        frame_nxt_s = frame_sel;
        if (vs_tick_s) begin
            case (state_r)
                ANIM_IDLE: begin
                    if (walking) begin
                        state_nxt_s = ANIM_WALK;
                        frame_nxt_s = 2'd1;
                        step_nxt_s  = '0;
                    end else begin
                        frame_nxt_s = 2'd0;
                        step_nxt_s  = '0;
                    end
                end
                ANIM_WALK: begin
                    if (!walking) begin
                        state_nxt_s = ANIM_IDLE;
                        frame_nxt_s = 2'd0;
                        step_nxt_s  = '0;
                    end else if (step_r == STEP_LAST) begin
                        step_nxt_s  = '0;
                        frame_nxt_s = (frame_sel == 2'd3) ? 2'd1 : (frame_sel + 2'd1);
                    end else begin
                        step_nxt_s  = step_r + STEP_W'(1);
                    end
                end
                default: begin
                    state_nxt_s = ANIM_IDLE;
                    frame_nxt_s = 2'd0;
                    step_nxt_s  = '0;
                end
            endcase
        end else begin
            state_nxt_s = state_r;
            step_nxt_s  = step_r;
            frame_nxt_s = frame_sel;
        end
    end

    // Animation state, step counter and frame select registers
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state_r   <= ANIM_IDLE;
            step_r    <= '0;
            frame_sel <= 2'd0;
        end else begin
            state_r   <= state_nxt_s;
            step_r    <= step_nxt_s;
            frame_sel <= frame_nxt_s;
        end
    end

    // Zero-extended operands keep off-screen offsets negative instead of wrapping
    always_comb begin
        dx_s     = $signed({1'b0, DrawX}) - $signed({1'b0, MarioX});
        dy_s     = $signed({1'b0, DrawY}) - $signed({1'b0, MarioY});
        in_box_s = (dx_s >= 11'sd0) && (dx_s < $signed(11'(SPR_W))) &&
                   (dy_s >= 11'sd0) && (dy_s < $signed(11'(SPR_H)));
        col_s    = face_left ? (5'(SPR_W - 1) - dx_s[4:0]) : dx_s[4:0];
        addr_s   = in_box_s ? sprite_addr(dy_s[4:0], col_s) : 9'd0;
    end

    // Stage 1: ROM address and in-box flag
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            read_address <= 9'd0;
            in_box_d1_r  <= 1'b0;
        end else begin
            read_address <= addr_s;
            in_box_d1_r  <= in_box_s;
        end
    end

    assign opaque_s = in_box_d1_r && (rom_color != KEY_COLOR);

    // Stage 2: keyed pixel towards the colour mapper
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            sprite_on    <= 1'b0;
            sprite_color <= 24'h0;
        end else begin
            sprite_on    <= opaque_s;
            sprite_color <= opaque_s ? rom_color : 24'h0;
        end
    end

endmodule

// File: tb/tb_mario_sprite_fetch.sv
// Scoreboard bench for mario_sprite_fetch: stimulus pushes timed expectations
// from a behavioural model, a negedge monitor pops and compares them.
module tb_mario_sprite_fetch;

    logic        Clk = 1'b0;
    logic        Reset_n;
    logic        frame_clk;
    logic [9:0]  DrawX, DrawY, MarioX, MarioY;
    logic        walking, face_left;
    logic [8:0]  read_address;
    logic [1:0]  frame_sel;
    logic [23:0] rom_color;
    logic        sprite_on;
    logic [23:0] sprite_color;

    logic [23:0] rom [0:3][0:440];

    int n_cmp = 0;
    int n_bad = 0;
    int cyc   = 0;

    // model state: pulses seen while walking, and resulting frame
    int walk_pulses = 0;
    int mframe      = 0;

    typedef struct {
        int          due;
        int          kind;   // 0 address, 1 sprite_on, 2 colour, 3 frame_sel
        logic [31:0] val;
    } exp_t;
    exp_t sb[$];

    mario_sprite_fetch dut (
        .Clk          (Clk),
        .Reset_n      (Reset_n),
        .frame_clk    (frame_clk),
        .DrawX        (DrawX),
        .DrawY        (DrawY),
        .MarioX       (MarioX),
        .MarioY       (MarioY),
        .walking      (walking),
        .face_left    (face_left),
        .read_address (read_address),
        .frame_sel    (frame_sel),
        .rom_color    (rom_color),
        .sprite_on    (sprite_on),
        .sprite_color (sprite_color)
    );

    assign rom_color = (read_address <= 9'd440) ? rom[frame_sel][read_address] : 24'h0;

    always #5 Clk = ~Clk;

    always @(posedge Clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s at cycle %0d: got %h, expected %h", name, cyc, act, exp);
        end
    endtask

    task automatic push(input int due, input int kind, input logic [31:0] val);
        exp_t e;
        e.due = due; e.kind = kind; e.val = val;
        sb.push_back(e);
    endtask

    // monitor: compare every expectation that falls due on this cycle
    always @(negedge Clk) begin
        for (int i = sb.size() - 1; i >= 0; i--) begin
            if (sb[i].due <= cyc) begin
                if (sb[i].due < cyc) begin
                    check("sb_stale", 32'(sb[i].due), 32'(cyc));
                end else begin
                    case (sb[i].kind)
                        0:       check("read_address", 32'(read_address), sb[i].val);
                        1:       check("sprite_on",    32'(sprite_on),    sb[i].val);
                        2:       check("sprite_color", 32'(sprite_color), sb[i].val);
                        default: check("frame_sel",    32'(frame_sel),    sb[i].val);
                    endcase
                end
                sb.delete(i);
            end
        end
    end

    // Behavioural model of one scan pixel, in plain integer arithmetic
    task automatic drive_pixel(input int mx, input int my, input int px, input int py, input bit fl);
        int dx, dy, col, addr;
        bit inb, on;
        logic [23:0] c;
        @(posedge Clk); #1;
        MarioX = 10'(mx); MarioY = 10'(my); DrawX = 10'(px); DrawY = 10'(py); face_left = fl;
        dx   = int'(DrawX) - int'(MarioX);
        dy   = int'(DrawY) - int'(MarioY);
        inb  = (dx >= 0) && (dx < 21) && (dy >= 0) && (dy < 21);
        col  = fl ? (20 - dx) : dx;
        addr = inb ? (dy * 21 + col) : 0;
        c    = rom[mframe][addr];
        on   = inb && (c != 24'h800080);
        push(cyc + 1, 0, 32'(addr));
        push(cyc + 2, 1, 32'(on));
        push(cyc + 2, 2, on ? 32'(c) : 32'h0);
    endtask

    task automatic vs_pulse();
        @(posedge Clk); #1;
        frame_clk = 1'b1;
        if (walking) begin
            walk_pulses++;
            mframe = 1 + ((walk_pulses - 1) / 6) % 3;
        end else begin
            walk_pulses = 0;
            mframe = 0;
        end
        push(cyc + 6, 3, 32'(mframe));
        repeat (4) @(posedge Clk);
        #1 frame_clk = 1'b0;
        repeat (4) @(posedge Clk);
    endtask

    task automatic drain();
        repeat (4) @(posedge Clk);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, %0d expectations pending", sb.size());
        $fatal(1);
    end

    initial begin
        for (int f = 0; f < 4; f++)
            for (int a = 0; a <= 440; a++)
                rom[f][a] = ($urandom_range(0, 7) == 0) ? 24'h800080 : 24'($urandom);

        // 1: reset with random inputs
        Reset_n = 1'b0; frame_clk = 1'b0; walking = 1'b0; face_left = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(posedge Clk); #1;
            DrawX = 10'($urandom); DrawY = 10'($urandom);
            MarioX = DrawX - 10'd3; MarioY = DrawY - 10'd3;
            walking = 1'($urandom); face_left = 1'($urandom); frame_clk = 1'($urandom);
            @(negedge Clk);
            check("rst_read_address", 32'(read_address), 32'h0);
            check("rst_sprite_on",    32'(sprite_on),    32'h0);
            check("rst_sprite_color", 32'(sprite_color), 32'h0);
            check("rst_frame_sel",    32'(frame_sel),    32'h0);
        end
        frame_clk = 1'b0; walking = 1'b0;
        @(posedge Clk); #1 Reset_n = 1'b1;
        repeat (6) @(negedge Clk);
        check("post_rst_frame_sel", 32'(frame_sel), 32'h0);

        // 2 and 3: fixed address and keying cases
        rom[0][47] = 24'h800080;
        rom[0][57] = 24'hF83800;
        drive_pixel(100, 50, 105, 52, 1'b0);
        push(cyc + 1, 0, 32'd47);
        push(cyc + 2, 1, 32'd0);
        drive_pixel(100, 50, 105, 52, 1'b1);
        push(cyc + 1, 0, 32'd57);
        push(cyc + 2, 1, 32'd1);
        push(cyc + 2, 2, 32'hF83800);
        drain();

        // 4: box bounds at the left edge
        drive_pixel(0, 50, 1023, 52, 1'b0);
        push(cyc + 1, 0, 32'd0);
        push(cyc + 2, 1, 32'd0);
        drive_pixel(0, 50, 21, 52, 1'b0);
        push(cyc + 1, 0, 32'd0);
        push(cyc + 2, 1, 32'd0);
        drive_pixel(0, 0, 20, 20, 1'b1);
        drive_pixel(5, 1020, 5, 3, 1'b0);
        drain();

        // random pixels around the box, standing frame
        for (int i = 0; i < 120; i++) begin
            int mx, my;
            mx = $urandom_range(0, 1023); my = $urandom_range(0, 1023);
            drive_pixel(mx, my, (mx + $urandom_range(0, 27) - 3) & 1023,
                        (my + $urandom_range(0, 27) - 3) & 1023, 1'($urandom));
        end
        drain();

        // 5: walk animation
        walking = 1'b1;
        for (int p = 0; p < 20; p++) vs_pulse();
        for (int i = 0; i < 60; i++) begin
            int mx, my;
            mx = $urandom_range(0, 1000); my = $urandom_range(0, 1000);
            drive_pixel(mx, my, (mx + $urandom_range(0, 24) - 2) & 1023,
                        (my + $urandom_range(0, 24) - 2) & 1023, 1'($urandom));
        end
        drain();
        walking = 1'b0;
        vs_pulse();
        drain();

        // 6: async reset while showing frame 3
        walking = 1'b1;
        for (int p = 0; p < 13; p++) vs_pulse();
        drain();
        check("walk_frame3", 32'(frame_sel), 32'd3);
        @(negedge Clk); #2;
        Reset_n = 1'b0;
        #1;
        check("async_rst_frame_sel",    32'(frame_sel),    32'h0);
        check("async_rst_sprite_on",    32'(sprite_on),    32'h0);
        check("async_rst_sprite_color", 32'(sprite_color), 32'h0);
        check("async_rst_read_address", 32'(read_address), 32'h0);
        walking = 1'b0; walk_pulses = 0; mframe = 0;
        @(posedge Clk); #1 Reset_n = 1'b1;
        vs_pulse();
        drain();

        check("sb_empty", 32'(sb.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
